// File: rtl/rgbw_spi_receiver.sv
// SPI mode-0 slave front end for the RGBW controller: synchronises the pins, assembles
// MSB-first bytes, presents them with a stretched rdy pulse and echoes the previous byte on MISO.
module rgbw_spi_receiver #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RDY_HOLD    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] buffRx_spi,
    output logic       rdy,
    output logic       byte_err,
    output logic       overrun
);

    localparam int unsigned        HOLD_W    = $clog2(RDY_HOLD + 1);
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(RDY_HOLD - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_prev;

    state_t             r_state;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_rx_sr;
    logic [7:0]         r_tx_sr;
    logic [7:0]         r_buff;
    logic [HOLD_W-1:0]  r_hold;
    logic               r_rdy;
    logic               r_err;
    logic               r_ovr;
    logic               r_miso;

    logic               w_sck_s;
    logic               w_cs_s;
    logic               w_mosi_s;
    logic               w_sck_rise;
    logic               w_sck_fall;
    logic [7:0]         w_byte;

    state_t             w_state_nxt;
    logic [2:0]         w_bit_cnt_nxt;
    logic [7:0]         w_rx_nxt;
    logic [7:0]         w_tx_nxt;
    logic [7:0]         w_buff_nxt;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic               w_rdy_nxt;
    logic               w_err_nxt;
    logic               w_ovr_nxt;
    logic               w_miso_nxt;
    logic               w_done;

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_prev;
    assign w_sck_fall = ~w_sck_s & r_sck_prev;
    assign w_byte     = {r_rx_sr[6:0], w_mosi_s};

    assign spi_miso   = r_miso;
    assign buffRx_spi = r_buff;
    assign rdy        = r_rdy;
    assign byte_err   = r_err;
    assign overrun    = r_ovr;

    // Pin synchronisers; cs_n idles deasserted so reset never looks like a select
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sck_prev  <= w_sck_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_rx_sr   <= '0;
            r_tx_sr   <= '0;
            r_buff    <= '0;
            r_hold    <= '0;
            r_rdy     <= 1'b0;
            r_err     <= 1'b0;
            r_ovr     <= 1'b0;
            r_miso    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_rx_sr   <= w_rx_nxt;
            r_tx_sr   <= w_tx_nxt;
            r_buff    <= w_buff_nxt;
            r_hold    <= w_hold_nxt;
            r_rdy     <= w_rdy_nxt;
            r_err     <= w_err_nxt;
            r_ovr     <= w_ovr_nxt;
            r_miso    <= w_miso_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_rx_nxt      = r_rx_sr;
        w_tx_nxt      = r_tx_sr;
        w_buff_nxt    = r_buff;
        w_hold_nxt    = r_hold;
        w_rdy_nxt     = r_rdy;
        w_err_nxt     = 1'b0;
        w_ovr_nxt     = r_ovr;
        w_miso_nxt    = 1'b0;
        w_done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_bit_cnt_nxt = '0;
                if (!w_cs_s) begin
                    w_tx_nxt    = r_buff;
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // Deselect takes priority over a coincident sck edge
                if (w_cs_s) begin
                    w_state_nxt   = ST_IDLE;
                    w_bit_cnt_nxt = '0;
                    w_err_nxt     = (r_bit_cnt != 3'd0);
                end else if (w_sck_rise) begin
                    w_rx_nxt = w_byte;
                    if (r_bit_cnt == 3'd7) begin
                        w_done        = 1'b1;
                        w_buff_nxt    = w_byte;
                        w_tx_nxt      = w_byte;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end else if (w_sck_fall && (r_bit_cnt != 3'd0)) begin
                    w_tx_nxt = {r_tx_sr[6:0], 1'b0};
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A new byte restarts the hold window; one landing inside it is an overrun
        if (w_done) begin
            w_rdy_nxt  = 1'b1;
            w_hold_nxt = HOLD_INIT;
            if (r_rdy) begin
                w_ovr_nxt = 1'b1;
            end
        end else if (r_rdy) begin
            if (r_hold == '0) begin
                w_rdy_nxt = 1'b0;
            end else begin
                w_hold_nxt = r_hold - HOLD_W'(1);
            end
        end

        w_miso_nxt = (w_state_nxt == ST_ACTIVE) ? w_tx_nxt[7] : 1'b0;
    end

endmodule

// File: tb/tb_rgbw_spi_receiver.sv
// Bench for rgbw_spi_receiver: vector table, latency/abort/overrun/reset sequences and
// random frames checked against a byte-level model of received data and MISO echo.
module tb_rgbw_spi_receiver;

    localparam int unsigned RDY_HOLD = 4;
    localparam int unsigned OVR_HOLD = 40;

    logic       clk;
    logic       reset;
    logic       spi_sck;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] buffRx_spi;
    logic       rdy;
    logic       byte_err;
    logic       overrun;

    logic       o2_miso;
    logic [7:0] o2_buff;
    logic       o2_rdy;
    logic       o2_err;
    logic       o2_overrun;

    rgbw_spi_receiver #(.SYNC_STAGES(2), .RDY_HOLD(RDY_HOLD)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .spi_sck    (spi_sck),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .buffRx_spi (buffRx_spi),
        .rdy        (rdy),
        .byte_err   (byte_err),
        .overrun    (overrun)
    );

    // Long-hold instance so legal sck rates can land a byte inside the rdy window
    rgbw_spi_receiver #(.SYNC_STAGES(2), .RDY_HOLD(OVR_HOLD)) u_ovr (
        .clk        (clk),
        .reset      (reset),
        .spi_sck    (spi_sck),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (o2_miso),
        .buffRx_spi (o2_buff),
        .rdy        (o2_rdy),
        .byte_err   (o2_err),
        .overrun    (o2_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         rdy_rises = 0;
    int         rises2 = 0;
    int         err_cycles = 0;
    int         mon_len = 0;
    logic       mon_prev = 1'b0;
    logic       mon_prev2 = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_last;

    typedef struct {
        logic [7:0] data;
        bit         new_cs;
        int         gap;
        logic [7:0] exp_buff;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_start();
        spi_cs_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_end(input int h, input int gap);
        wait_clk(h);
        spi_cs_n = 1'b1;
        wait_clk(gap);
    endtask

    // Master side: MOSI set while sck low, MISO sampled just before each rising edge
    task automatic spi_bits(input logic [7:0] data, input int nbits, input int h,
                            output logic [7:0] miso_cap);
        miso_cap = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = data[7-i];
            wait_clk(h);
            miso_cap[7-i] = spi_miso;
            spi_sck = 1'b1;
            wait_clk(h);
            spi_sck = 1'b0;
        end
    endtask

    // rdy monitor: captures each presented byte and checks the high-time of every pulse
    always @(negedge clk) begin
        if (rdy === 1'b1 && mon_prev === 1'b0) begin
            got_q.push_back(buffRx_spi);
            rdy_rises++;
            mon_len = 1;
        end else if (rdy === 1'b1) begin
            mon_len++;
        end
        if (rdy === 1'b0 && mon_prev === 1'b1) begin
            check("rdy_width", 32'(mon_len), 32'(RDY_HOLD));
        end
        mon_prev = rdy;
        if (byte_err === 1'b1) err_cycles++;
        if (o2_rdy === 1'b1 && mon_prev2 === 1'b0) rises2++;
        mon_prev2 = o2_rdy;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] cap;
        logic [7:0] d;
        bit         cs_on;
        int         lat;
        int         r1;
        int         r2;
        int         e_err;
        int         nb;

        vecs[0] = '{8'h55, 1'b1, 16, 8'h55, 8'h00};
        vecs[1] = '{8'h80, 1'b0, 16, 8'h80, 8'h55};
        vecs[2] = '{8'h12, 1'b0, 16, 8'h12, 8'h80};
        vecs[3] = '{8'hA5, 1'b1, 0,  8'hA5, 8'h12};
        vecs[4] = '{8'h3C, 1'b0, 0,  8'h3C, 8'hA5};
        vecs[5] = '{8'h00, 1'b1, 0,  8'h00, 8'h3C};

        // Reset held with pins toggling
        reset    = 1'b0;
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_clk(1);
            spi_sck  = ~spi_sck;
            spi_cs_n = 1'($urandom);
            spi_mosi = 1'($urandom);
            wait_clk(1);
            check("reset_outputs", {23'd0, buffRx_spi, rdy, byte_err, overrun, spi_miso}, 32'd0);
        end
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        wait_clk(2);
        reset = 1'b1;
        wait_clk(10);
        check("post_reset_rdy_count", 32'(rdy_rises), 32'd0);
        check("post_reset_outputs", {23'd0, buffRx_spi, rdy, byte_err, overrun, spi_miso}, 32'd0);

        // Vector table: data, MISO echo across bytes and chip selects
        cs_on = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].new_cs) begin
                if (cs_on) cs_end(8, 16);
                cs_start();
                cs_on = 1'b1;
            end
            spi_bits(vecs[i].data, 8, 8, cap);
            wait_clk(vecs[i].gap);
            check($sformatf("vec%0d_buff", i), 32'(buffRx_spi), 32'(vecs[i].exp_buff));
            check($sformatf("vec%0d_miso", i), 32'(cap), 32'(vecs[i].exp_miso));
        end
        cs_end(8, 16);
        check("vec_rdy_count", 32'(rdy_rises), 32'd6);
        m_last = 8'h00;

        // Latency from the 8th sck rise to rdy
        cs_start();
        spi_bits(8'h96, 7, 8, cap);
        spi_mosi = 1'b0;
        wait_clk(8);
        spi_sck = 1'b1;
        lat = 0;
        while (rdy !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("rdy_latency", 32'(lat), 32'd3);
        @(negedge clk);
        wait_clk(5);
        spi_sck = 1'b0;
        cs_end(8, 16);
        check("latency_buff", 32'(buffRx_spi), 32'h96);
        m_last = 8'h96;

        // Abort after 5 bits, then a clean byte
        r1 = rdy_rises;
        e_err = err_cycles;
        cs_start();
        spi_bits(8'hFF, 5, 8, cap);
        cs_end(8, 16);
        check("abort_err_cycles", 32'(err_cycles), 32'(e_err + 1));
        check("abort_buff", 32'(buffRx_spi), 32'h96);
        check("abort_rdy_count", 32'(rdy_rises), 32'(r1));
        cs_start();
        spi_bits(8'hC3, 8, 8, cap);
        cs_end(8, 16);
        check("after_abort_buff", 32'(buffRx_spi), 32'hC3);
        check("after_abort_miso", 32'(cap), 32'h96);
        m_last = 8'hC3;

        // Random frames against the byte-level model
        got_q.delete();
        exp_q.delete();
        e_err = err_cycles;
        for (int f = 0; f < 15; f++) begin
            cs_start();
            nb = int'($urandom_range(1, 3));
            for (int b = 0; b < nb; b++) begin
                d = 8'($urandom);
                spi_bits(d, 8, 4, cap);
                check("rand_miso", 32'(cap), 32'(m_last));
                exp_q.push_back(d);
                m_last = d;
            end
            if ($urandom_range(0, 2) == 0) begin
                spi_bits(8'($urandom), int'($urandom_range(1, 7)), 4, cap);
                e_err++;
            end
            cs_end(4, 16);
        end
        check("rand_byte_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("rand_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check("rand_err_cycles", 32'(err_cycles), 32'(e_err));

        // Overrun on the long-hold instance
        check("pre_overrun2", 32'(o2_overrun), 32'd0);
        r1 = rdy_rises;
        r2 = rises2;
        cs_start();
        spi_bits(8'h5A, 8, 2, cap);
        spi_bits(8'hE7, 8, 2, cap);
        wait_clk(4);
        check("ovr2_buff", 32'(o2_buff), 32'hE7);
        check("ovr2_flag", 32'(o2_overrun), 32'd1);
        check("ovr2_rdy_high", 32'(o2_rdy), 32'd1);
        cs_end(2, 60);
        check("ovr2_single_rdy", 32'(rises2), 32'(r2 + 1));
        check("ovr_main_rdy_count", 32'(rdy_rises), 32'(r1 + 2));
        check("ovr_main_flag", 32'(overrun), 32'd0);
        cs_start();
        spi_bits(8'h11, 8, 8, cap);
        cs_end(8, 60);
        check("ovr2_sticky", 32'(o2_overrun), 32'd1);
        check("sticky_main_buff", 32'(buffRx_spi), 32'h11);
        check("sticky_miso", 32'(cap), 32'hE7);

        // Async reset mid-byte
        cs_start();
        spi_bits(8'hAA, 3, 8, cap);
        wait_clk(2);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {23'd0, buffRx_spi, rdy, byte_err, overrun, spi_miso}, 32'd0);
        check("async_reset_ovr2", 32'(o2_overrun), 32'd0);
        @(negedge clk);
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(5);
        m_last = 8'h00;
        r1 = rdy_rises;
        e_err = err_cycles;
        cs_start();
        spi_bits(8'h55, 8, 8, cap);
        cs_end(8, 16);
        check("post_async_buff", 32'(buffRx_spi), 32'h55);
        check("post_async_miso", 32'(cap), 32'(m_last));
        check("post_async_rdy_count", 32'(rdy_rises), 32'(r1 + 1));
        check("post_async_err", 32'(err_cycles), 32'(e_err));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
